// File: rtl/rv_core_pkg.sv
// -----------------------------------------------------------------------------
// rv_core_pkg
// Shared types and constants for the RV32I multi-cycle sequencer:
//   - state_e  : sequencer FSM states (encoding visible on the debug port)
//   - iclass_e : instruction class latched in DECODE
//   - opcode, ALU op and branch funct3 constants
//   - helpers for ALU op selection and branch resolution
// -----------------------------------------------------------------------------
package rv_core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  // CL_NONE is the cleared value held from reset until the first DECODE.
  typedef enum logic [2:0] {
    CL_NONE = 3'd0,
    CL_R    = 3'd1,
    CL_I    = 3'd2,
    CL_LW   = 3'd3,
    CL_SW   = 3'd4,
    CL_BR   = 3'd5
  } iclass_e;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b1001;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b1101;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  // ALU op for R/I arithmetic. i_sub_en is only honoured for funct3 000,
  // and the caller passes 0 for I-type so addi never becomes a subtract.
  function automatic logic [3:0] f_alu_funct3(input logic [2:0] i_funct3,
                                              input logic       i_sub_en);
    logic [3:0] w_op;
    case (i_funct3)
      3'b000:  w_op = i_sub_en ? ALU_SUB : ALU_ADD;
      3'b001:  w_op = ALU_SLL;
      3'b100:  w_op = ALU_XOR;
      3'b101:  w_op = ALU_SRL;
      3'b110:  w_op = ALU_OR;
      3'b111:  w_op = ALU_AND;
      default: w_op = ALU_NONE;
    endcase
    return w_op;
  endfunction

  // Unsupported branch funct3 values resolve as not taken.
  function automatic logic f_branch_taken(input logic [2:0] i_funct3,
                                          input logic       i_eq,
                                          input logic       i_lt);
    logic w_taken;
    case (i_funct3)
      F3_BEQ:  w_taken = i_eq;
      F3_BNE:  w_taken = !i_eq;
      F3_BLT:  w_taken = i_lt;
      F3_BGE:  w_taken = !i_lt;
      default: w_taken = 1'b0;
    endcase
    return w_taken;
  endfunction

endpackage

// File: rtl/rv_seq_decode.sv
// -----------------------------------------------------------------------------
// rv_seq_decode
// Combinational instruction classifier.
// Ports:
//   i_instr   [31:0]  instruction register contents
//   o_iclass          instruction class (CL_NONE when illegal)
//   o_legal           opcode is one of R, I, LW, SW, BR
//   o_alu_op  [3:0]   ALU operation for the class
// -----------------------------------------------------------------------------
module rv_seq_decode
  import rv_core_pkg::*;
(
  input  logic [31:0] i_instr,
  output iclass_e     o_iclass,
  output logic        o_legal,
  output logic [3:0]  o_alu_op
);

  // Only opcode, funct3 and instr[30] matter to the sequencer.
  logic w_unused_bits;
  assign w_unused_bits = ^{i_instr[31], i_instr[29:15], i_instr[11:7]};

  always_comb begin
    o_iclass = CL_NONE;
    o_legal  = 1'b0;
    o_alu_op = ALU_NONE;
    case (i_instr[6:0])
      OP_R: begin
        o_iclass = CL_R;
        o_legal  = 1'b1;
        o_alu_op = f_alu_funct3(i_instr[14:12], i_instr[30]);
      end
      OP_I: begin
        o_iclass = CL_I;
        o_legal  = 1'b1;
        o_alu_op = f_alu_funct3(i_instr[14:12], 1'b0);
      end
      OP_LW: begin
        o_iclass = CL_LW;
        o_legal  = 1'b1;
        o_alu_op = ALU_ADD;
      end
      OP_SW: begin
        o_iclass = CL_SW;
        o_legal  = 1'b1;
        o_alu_op = ALU_ADD;
      end
      OP_BR: begin
        o_iclass = CL_BR;
        o_legal  = 1'b1;
        o_alu_op = ALU_ADD;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// rv_multicycle_sequencer
// Steps the shared RV32I datapath through FETCH/DECODE/EXEC/MEM/WB, issues
// stage enables and datapath selects, resolves branches, handles memory wait
// states with a bus timeout, traps on illegal opcodes and counts retirements.
// Parameters:
//   MEM_TIMEOUT  wait cycles tolerated on imem/dmem ready before trapping (>=1)
// Ports:
//   i_clk, i_rst_n (async, active-low)
//   i_instr[31:0], i_imem_ready, i_dmem_ready, i_br_eq, i_br_lt
//   o_imem_req, o_ir_we, o_pc_we, o_pc_sel, o_dmem_req, o_dmem_we,
//   o_reg_wen, o_wb_sel, o_imm_sel, o_b_sel, o_a_sel, o_alu_op[3:0],
//   o_state[2:0] (debug), o_trap, o_bus_err, o_retired[31:0]
// -----------------------------------------------------------------------------
module rv_multicycle_sequencer
  import rv_core_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_instr,
  input  logic        i_imem_ready,
  input  logic        i_dmem_ready,
  input  logic        i_br_eq,
  input  logic        i_br_lt,
  output logic        o_imem_req,
  output logic        o_ir_we,
  output logic        o_pc_we,
  output logic        o_pc_sel,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic        o_reg_wen,
  output logic        o_wb_sel,
  output logic        o_imm_sel,
  output logic        o_b_sel,
  output logic        o_a_sel,
  output logic [3:0]  o_alu_op,
  output logic [2:0]  o_state,
  output logic        o_trap,
  output logic        o_bus_err,
  output logic [31:0] o_retired
);

  localparam int                CNT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MEM_TIMEOUT);

  state_e            r_state;
  state_e            w_state_next;
  iclass_e           r_iclass;
  logic [3:0]        r_alu_op;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_bus_err;
  logic [31:0]       r_retired;

  iclass_e           w_dec_iclass;
  logic              w_dec_legal;
  logic [3:0]        w_dec_alu_op;
  logic              w_wait_hit;
  logic              w_timeout;

  rv_seq_decode u_decode (
    .i_instr  (i_instr),
    .o_iclass (w_dec_iclass),
    .o_legal  (w_dec_legal),
    .o_alu_op (w_dec_alu_op)
  );

  assign w_wait_hit = (r_wait_cnt == CNT_MAX);

  // Next state and stage enables. Everything is decoded from r_state and
  // r_iclass except ir_we, pc_we in MEM and pc_sel in EXEC, which follow the
  // ready/comparator inputs within the cycle.
  always_comb begin
    w_state_next = r_state;
    w_timeout    = 1'b0;
    o_imem_req   = 1'b0;
    o_ir_we      = 1'b0;
    o_pc_we      = 1'b0;
    o_pc_sel     = 1'b0;
    o_dmem_req   = 1'b0;
    o_dmem_we    = 1'b0;
    o_reg_wen    = 1'b0;
    case (r_state)
      ST_IDLE: w_state_next = ST_FETCH;
      ST_FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_ready) begin
          o_ir_we      = 1'b1;
          w_state_next = ST_DECODE;
        end else if (w_wait_hit) begin
          w_timeout    = 1'b1;
          w_state_next = ST_TRAP;
        end
      end
      ST_DECODE: w_state_next = w_dec_legal ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        case (r_iclass)
          CL_R, CL_I:   w_state_next = ST_WB;
          CL_LW, CL_SW: w_state_next = ST_MEM;
          CL_BR: begin
            o_pc_we      = 1'b1;
            o_pc_sel     = f_branch_taken(i_instr[14:12], i_br_eq, i_br_lt);
            w_state_next = ST_FETCH;
          end
          default:      w_state_next = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = (r_iclass == CL_SW);
        if (i_dmem_ready) begin
          if (r_iclass == CL_SW) begin
            // Stores retire here; there is nothing to write back.
            o_pc_we      = 1'b1;
            w_state_next = ST_FETCH;
          end else begin
            w_state_next = ST_WB;
          end
        end else if (w_wait_hit) begin
          w_timeout    = 1'b1;
          w_state_next = ST_TRAP;
        end
      end
      ST_WB: begin
        o_reg_wen    = 1'b1;
        o_pc_we      = 1'b1;
        w_state_next = ST_FETCH;
      end
      ST_TRAP: w_state_next = ST_TRAP;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Static datapath selects, held from EXEC through WB.
  always_comb begin
    o_imm_sel = 1'b0;
    o_b_sel   = 1'b0;
    o_a_sel   = 1'b0;
    o_wb_sel  = 1'b0;
    if (r_state inside {ST_EXEC, ST_MEM, ST_WB}) begin
      case (r_iclass)
        CL_R: o_wb_sel = 1'b1;
        CL_I: begin
          o_imm_sel = 1'b1;
          o_b_sel   = 1'b1;
          o_wb_sel  = 1'b1;
        end
        CL_LW, CL_SW: begin
          o_imm_sel = 1'b1;
          o_b_sel   = 1'b1;
        end
        CL_BR: begin
          o_imm_sel = 1'b1;
          o_b_sel   = 1'b1;
          o_a_sel   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_iclass   <= CL_NONE;
      r_alu_op   <= ALU_NONE;
      r_wait_cnt <= '0;
      r_bus_err  <= 1'b0;
      r_retired  <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_DECODE) begin
        r_iclass <= w_dec_iclass;
        r_alu_op <= w_dec_alu_op;
      end
      // Any state change restarts the wait count, so it is zero on entry to
      // FETCH/MEM; remaining in FETCH/MEM means the ready input was low.
      if (w_state_next != r_state) begin
        r_wait_cnt <= '0;
      end else if (r_state == ST_FETCH || r_state == ST_MEM) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_bus_err <= 1'b1;
      end
      if (o_pc_we) begin
        r_retired <= r_retired + 32'd1;
      end
    end
  end

  assign o_state   = r_state;
  assign o_alu_op  = r_alu_op;
  assign o_trap    = (r_state == ST_TRAP);
  assign o_bus_err = r_bus_err;
  assign o_retired = r_retired;

endmodule

// File: tb/tb_rv_multicycle_sequencer.sv
module tb_rv_multicycle_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] i_instr = 32'h0;
  logic        i_imem_ready = 1'b0;
  logic        i_dmem_ready = 1'b0;
  logic        i_br_eq = 1'b0;
  logic        i_br_lt = 1'b0;
  logic        o_imem_req, o_ir_we, o_pc_we, o_pc_sel, o_dmem_req, o_dmem_we;
  logic        o_reg_wen, o_wb_sel, o_imm_sel, o_b_sel, o_a_sel;
  logic [3:0]  o_alu_op;
  logic [2:0]  o_state;
  logic        o_trap, o_bus_err;
  logic [31:0] o_retired;

  rv_multicycle_sequencer #(.MEM_TIMEOUT(15)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_instr(i_instr),
    .i_imem_ready(i_imem_ready), .i_dmem_ready(i_dmem_ready),
    .i_br_eq(i_br_eq), .i_br_lt(i_br_lt),
    .o_imem_req(o_imem_req), .o_ir_we(o_ir_we), .o_pc_we(o_pc_we),
    .o_pc_sel(o_pc_sel), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
    .o_reg_wen(o_reg_wen), .o_wb_sel(o_wb_sel), .o_imm_sel(o_imm_sel),
    .o_b_sel(o_b_sel), .o_a_sel(o_a_sel), .o_alu_op(o_alu_op),
    .o_state(o_state), .o_trap(o_trap), .o_bus_err(o_bus_err),
    .o_retired(o_retired)
  );

  always #5 i_clk = ~i_clk;

  localparam logic [31:0] I_ADD = 32'h00208133;
  localparam logic [31:0] I_LW  = 32'h0000A083;
  localparam logic [31:0] I_SW  = 32'h0020A023;

  logic [19:0] w_outs;
  assign w_outs = {o_imem_req, o_ir_we, o_pc_we, o_pc_sel, o_dmem_req, o_dmem_we,
                   o_reg_wen, o_wb_sel, o_imm_sel, o_b_sel, o_a_sel, o_alu_op,
                   o_state, o_trap, o_bus_err};
  logic [5:0] w_enables;
  assign w_enables = {o_imem_req, o_ir_we, o_pc_we, o_dmem_req, o_dmem_we, o_reg_wen};

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_retired = 32'd0;

  typedef struct {
    logic [31:0] instr;
    logic        eq;
    logic        lt;
    int          dwait;
    logic [31:0] trace;   // one nibble per state, FETCH up to next FETCH
    logic [3:0]  alu;
    logic        ps;      // pc_sel during the pc_we cycle
    int          n_wen;
    int          n_dreq;
    logic        dwe;
    logic        imm;
    logic        b;
    logic        a;
    logic        wb;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Leaves the bench at negedge+1 of the first FETCH cycle.
  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    i_imem_ready = 1'b1;
    i_dmem_ready = 1'b0;
    #1;
    chk("reset_outs", {12'd0, w_outs}, 32'd0);
    chk("reset_retired", o_retired, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_imem_ready = 1'b0;
    @(negedge i_clk);
    #1;
    chk("idle_to_fetch", {29'd0, o_state}, 32'd1);
    exp_retired = 32'd0;
  endtask

  task automatic step();
    @(negedge i_clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] trace;
    int n_pcwe, n_wen, n_dreq, n_irwe;
    logic ps, dwe, imm, b, a, wb, done;
    logic [3:0] alu;
    trace = 0; n_pcwe = 0; n_wen = 0; n_dreq = 0; n_irwe = 0;
    ps = 0; dwe = 0; imm = 0; b = 0; a = 0; wb = 0; done = 0; alu = 0;
    i_instr = v.instr;
    i_br_eq = v.eq;
    i_br_lt = v.lt;
    i_imem_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      i_dmem_ready = (o_state == 3'd4) && (n_dreq >= v.dwait);
      #1;
      trace = {trace[27:0], 1'b0, o_state};
      if (o_pc_we) begin n_pcwe++; ps = o_pc_sel; end
      if (o_reg_wen) begin n_wen++; wb = o_wb_sel; end
      if (o_ir_we) n_irwe++;
      if (o_dmem_req) begin n_dreq++; dwe = dwe | o_dmem_we; end
      if (o_state == 3'd3) begin alu = o_alu_op; imm = o_imm_sel; b = o_b_sel; a = o_a_sel; end
      step();
      if (o_state == 3'd1 || o_state == 3'd6) begin done = 1; break; end
    end
    i_dmem_ready = 1'b0;
    exp_retired = exp_retired + 32'd1;
    $display("vec %0d instr=%08h trace=%0h alu=%0h pc_sel=%0b dreq=%0d retired=%0d",
             idx, v.instr, trace, alu, ps, n_dreq, o_retired);
    chk($sformatf("v%0d_done", idx), {31'd0, done}, 32'd1);
    chk($sformatf("v%0d_trace", idx), trace, v.trace);
    chk($sformatf("v%0d_alu_op", idx), {28'd0, alu}, {28'd0, v.alu});
    chk($sformatf("v%0d_pc_sel", idx), {31'd0, ps}, {31'd0, v.ps});
    chk($sformatf("v%0d_pc_we_cnt", idx), n_pcwe, 32'd1);
    chk($sformatf("v%0d_ir_we_cnt", idx), n_irwe, 32'd1);
    chk($sformatf("v%0d_reg_wen_cnt", idx), n_wen, v.n_wen);
    chk($sformatf("v%0d_dmem_req_cnt", idx), n_dreq, v.n_dreq);
    chk($sformatf("v%0d_dmem_we", idx), {31'd0, dwe}, {31'd0, v.dwe});
    chk($sformatf("v%0d_sel", idx), {29'd0, imm, b, a}, {29'd0, v.imm, v.b, v.a});
    if (v.n_wen != 0) chk($sformatf("v%0d_wb_sel", idx), {31'd0, wb}, {31'd0, v.wb});
    chk($sformatf("v%0d_retired", idx), o_retired, exp_retired);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic bad;
    //            instr         eq    lt   dw  trace         alu    ps  wen dr dwe   imm   b     a     wb
    vecs[0]  = '{32'h00208133, 1'b0, 1'b0, 0, 32'h1235,     4'h9, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // add
    vecs[1]  = '{32'h40208133, 1'b0, 1'b0, 0, 32'h1235,     4'h1, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // sub
    vecs[2]  = '{32'h0FF0C093, 1'b0, 1'b0, 0, 32'h1235,     4'h2, 1'b0, 1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1}; // xori
    vecs[3]  = '{32'h0020E133, 1'b0, 1'b0, 0, 32'h1235,     4'h3, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // or
    vecs[4]  = '{32'h0020F133, 1'b0, 1'b0, 0, 32'h1235,     4'h4, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // and
    vecs[5]  = '{32'h00209133, 1'b0, 1'b0, 0, 32'h1235,     4'h5, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // sll
    vecs[6]  = '{32'h0020D133, 1'b0, 1'b0, 0, 32'h1235,     4'hD, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // srl
    vecs[7]  = '{32'h40008093, 1'b0, 1'b0, 0, 32'h1235,     4'h9, 1'b0, 1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1}; // addi, bit30 set
    vecs[8]  = '{32'h00208463, 1'b1, 1'b0, 0, 32'h123,      4'h9, 1'b1, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}; // beq eq=1
    vecs[9]  = '{32'h00209463, 1'b1, 1'b0, 0, 32'h123,      4'h9, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}; // bne eq=1
    vecs[10] = '{32'h0020D463, 1'b0, 1'b0, 0, 32'h123,      4'h9, 1'b1, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}; // bge lt=0
    vecs[11] = '{32'h0020C463, 1'b0, 1'b1, 0, 32'h123,      4'h9, 1'b1, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}; // blt lt=1
    vecs[12] = '{32'h00208463, 1'b0, 1'b1, 0, 32'h123,      4'h9, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}; // beq eq=0
    vecs[13] = '{32'h0020E463, 1'b1, 1'b1, 0, 32'h123,      4'h9, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}; // funct3 110
    vecs[14] = '{32'h0000A083, 1'b0, 1'b0, 3, 32'h12344445, 4'h9, 1'b0, 1, 4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // lw, 3 waits
    vecs[15] = '{32'h0000A083, 1'b0, 1'b0, 0, 32'h12345,    4'h9, 1'b0, 1, 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // lw
    vecs[16] = '{32'h0020A023, 1'b0, 1'b0, 0, 32'h1234,     4'h9, 1'b0, 0, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // sw
    vecs[17] = '{32'h0020A023, 1'b0, 1'b0, 2, 32'h123444,   4'h9, 1'b0, 0, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // sw, 2 waits

    do_reset();
    for (int i = 0; i < 18; i++) run_vec(vecs[i], i);

    // Reset asserted while a load waits in MEM: request drops at once,
    // counter clears, no write-back.
    i_instr = I_LW; i_imem_ready = 1'b1; i_dmem_ready = 1'b0;
    n = 0;
    while (o_state != 3'd4 && n < 10) begin step(); n++; end
    step(); step();
    chk("midmem_req_held", {31'd0, o_dmem_req}, 32'd1);
    i_rst_n = 1'b0;
    #1;
    $display("txn midmem_reset state=%0d dmem_req=%0b retired=%0d", o_state, o_dmem_req, o_retired);
    chk("midmem_outs", {12'd0, w_outs}, 32'd0);
    chk("midmem_retired", o_retired, 32'd0);

    // Illegal opcode traps from DECODE and stays there.
    do_reset();
    i_instr = 32'h0000007F; i_imem_ready = 1'b1;
    step();
    chk("illegal_decode", {29'd0, o_state}, 32'd2);
    step();
    chk("illegal_state", {29'd0, o_state}, 32'd6);
    i_dmem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("illegal_flags%0d", k), {30'd0, o_trap, o_bus_err}, 32'd2);
      chk($sformatf("illegal_enables%0d", k), {26'd0, w_enables}, 32'd0);
      step();
    end
    $display("txn illegal state=%0d trap=%0b bus_err=%0b", o_state, o_trap, o_bus_err);
    i_dmem_ready = 1'b0;

    // imem_ready stuck low: 16 FETCH cycles then a bus-error trap.
    do_reset();
    i_instr = I_ADD; i_imem_ready = 1'b0;
    n = 0; bad = 1'b0;
    while (o_state == 3'd1 && n < 40) begin
      n++;
      if (!o_imem_req || o_ir_we) bad = 1'b1;
      step();
    end
    $display("txn fetch_timeout fetch_cycles=%0d state=%0d bus_err=%0b", n, o_state, o_bus_err);
    chk("fto_cycles", n, 32'd16);
    chk("fto_req_stable", {31'd0, bad}, 32'd0);
    chk("fto_state", {29'd0, o_state}, 32'd6);
    chk("fto_flags", {30'd0, o_trap, o_bus_err}, 32'd3);

    // Ready arriving in the 16th wait cycle wins over the timeout.
    do_reset();
    i_instr = I_ADD; i_imem_ready = 1'b0;
    repeat (15) step();
    chk("win_still_fetch", {29'd0, o_state}, 32'd1);
    i_imem_ready = 1'b1;
    #1;
    chk("win_ir_we", {31'd0, o_ir_we}, 32'd1);
    step();
    chk("win_decode", {29'd0, o_state}, 32'd2);
    n = 0;
    while (o_state != 3'd1 && n < 10) begin step(); n++; end
    $display("txn ready_wins state=%0d bus_err=%0b retired=%0d", o_state, o_bus_err, o_retired);
    chk("win_no_buserr", {30'd0, o_trap, o_bus_err}, 32'd0);
    chk("win_retired", o_retired, 32'd1);

    // dmem_ready stuck low on a store: 16 MEM cycles then a bus-error trap.
    do_reset();
    i_instr = I_SW; i_imem_ready = 1'b1; i_dmem_ready = 1'b0;
    n = 0;
    while (o_state != 3'd4 && n < 10) begin step(); n++; end
    n = 0; bad = 1'b0;
    while (o_state == 3'd4 && n < 40) begin
      n++;
      if (!o_dmem_req || !o_dmem_we || o_pc_we) bad = 1'b1;
      step();
    end
    $display("txn mem_timeout mem_cycles=%0d state=%0d bus_err=%0b", n, o_state, o_bus_err);
    chk("mto_cycles", n, 32'd16);
    chk("mto_req_stable", {31'd0, bad}, 32'd0);
    chk("mto_flags", {30'd0, o_trap, o_bus_err}, 32'd3);
    chk("mto_enables", {26'd0, w_enables}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
